// File: rtl/panel_pkg.sv
// panel_pkg: shared panel geometry, capture FSM states and pixel indexing
package panel_pkg;
  localparam int N_COLS_D = 7;
  localparam int N_ROWS_D = 5;
  typedef enum logic [1:0] {HUNT, WAIT, COMMIT} state_t;
  function automatic int pix_idx(input int c, input int r, input int n_rows = N_ROWS_D);
    return c * n_rows + r;
  endfunction
endpackage

// File: rtl/panel_frame_capture_col_decode.sv
// col_decode: normalise column polarity and classify the code as none, one-hot or multi
module col_decode #(
  parameter int N_COLS = 7,
  parameter int COL_ACTIVE_LOW = 0
) (
  input  logic [N_COLS-1:0] col,
  output logic [N_COLS-1:0] code,
  output logic              valid,
  output logic              multi,
  output logic              none,
  output logic [2:0]        index
);
  always_comb begin
    code = COL_ACTIVE_LOW != 0 ? ~col : col;
    index = '0;
    for (int i = 0; i < N_COLS; i++) if (code[i]) index = 3'(i);
  end
  assign none = code == '0;
  assign multi = (code & (code - N_COLS'(1))) != '0;
  assign valid = !none && !multi;
endmodule

// File: rtl/panel_frame_capture.sv
// panel_frame_capture: rebuild the multiplexed panel frame from column/row scan lines
module panel_frame_capture
  import panel_pkg::*;
#(
  parameter int N_COLS = N_COLS_D,
  parameter int N_ROWS = N_ROWS_D,
  parameter int SETTLE = 4,
  parameter int COL_ACTIVE_LOW = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_COLS-1:0]        col,
  input  logic [N_ROWS-1:0]        row,
  output logic [N_COLS*N_ROWS-1:0] frame,
  output logic                     frame_valid,
  output logic                     frame_changed,
  output logic                     col_err,
  output logic [2:0]               cur_col
);
  localparam int W = N_COLS * N_ROWS;
  logic [N_COLS-1:0] col_s1, col_s2, prev, code;
  logic [N_ROWS-1:0] row_s1, row_s2;
  logic valid, multi, none, stable;
  logic [2:0] index, exp_col;
  logic [3:0] cnt, run;
  logic [W-1:0] shadow;
  state_t state;

  function automatic logic [W-1:0] put(input logic [W-1:0] s, input logic [2:0] c, input logic [N_ROWS-1:0] r);
    logic [W-1:0] m = W'({N_ROWS{1'b1}}) << pix_idx(int'(c), 0, N_ROWS);
    return (s & ~m) | (W'(r) << pix_idx(int'(c), 0, N_ROWS));
  endfunction

  col_decode #(.N_COLS(N_COLS), .COL_ACTIVE_LOW(COL_ACTIVE_LOW)) u_dec (
    .col(col_s2), .code, .valid, .multi, .none, .index
  );

  // run = cycles the current code has already been held; fires stable exactly once per hold
  always_comb begin
    run = code != prev ? 4'd0 : cnt == 4'd15 ? cnt : cnt + 4'd1;
    stable = !none && run == 4'(SETTLE - 1);
  end

  always_ff @(posedge clk) begin
    frame_valid <= 1'b0;
    frame_changed <= 1'b0;
    col_err <= 1'b0;
    if (rst) begin
      col_s1 <= {N_COLS{COL_ACTIVE_LOW != 0}};
      col_s2 <= {N_COLS{COL_ACTIVE_LOW != 0}};
      row_s1 <= '0;
      row_s2 <= '0;
      prev <= '0;
      cnt <= '0;
      shadow <= '0;
      frame <= '0;
      cur_col <= '0;
      exp_col <= '0;
      state <= HUNT;
    end else begin
      col_s1 <= col;
      col_s2 <= col_s1;
      row_s1 <= row;
      row_s2 <= row_s1;
      prev <= code;
      cnt <= run;
      case (state)
        HUNT: if (stable && valid && index == '0) begin
          shadow <= put('0, 3'd0, row_s2);
          cur_col <= '0;
          exp_col <= 3'd1;
          state <= WAIT;
        end
        // re-settling on the column just sampled (after a short glitch) is not a new column
        WAIT: if (stable && !(valid && index == cur_col)) begin
          if (!multi && index == exp_col) begin
            shadow <= put(shadow, index, row_s2);
            cur_col <= index;
            exp_col <= exp_col + 3'd1;
            if (exp_col == 3'(N_COLS - 1)) state <= COMMIT;
          end else begin
            col_err <= 1'b1;
            shadow <= valid && index == '0 ? put('0, 3'd0, row_s2) : '0;
            if (valid && index == '0) begin
              cur_col <= '0;
              exp_col <= 3'd1;
            end else state <= HUNT;
          end
        end
        default: begin
          frame <= shadow;
          frame_valid <= 1'b1;
          frame_changed <= shadow != frame;
          exp_col <= '0;
          state <= WAIT;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_panel_frame_capture.sv
// tb_panel_frame_capture: directed scan vectors on an active-high and an active-low capture instance
module tb_panel_frame_capture;
  import panel_pkg::*;
  logic clk = 1'b0;
  logic rst;
  logic [6:0] col;
  logic [4:0] row;
  logic [34:0] frame_h, frame_l, want_frame;
  logic fv_h, fv_l, ch_h, ch_l, er_h, er_l;
  logic [2:0] cc_h, cc_l;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  panel_frame_capture #(.SETTLE(4)) dut (
    .clk, .rst, .col, .row, .frame(frame_h), .frame_valid(fv_h),
    .frame_changed(ch_h), .col_err(er_h), .cur_col(cc_h)
  );
  panel_frame_capture #(.SETTLE(4), .COL_ACTIVE_LOW(1)) dut_l (
    .clk, .rst, .col(~col), .row, .frame(frame_l), .frame_valid(fv_l),
    .frame_changed(ch_l), .col_err(er_l), .cur_col(cc_l)
  );

  typedef struct {
    logic [6:0] cv;
    logic [4:0] rv;
    int len;
    int fv;
    int er;
    int ch;
    int cc;
    bit chkf;
  } step_t;
  step_t steps[$];

  function automatic logic [4:0] pat(input int c);
    return (c % 2) != 0 ? 5'b01110 : 5'b10101;
  endfunction

  function automatic void push(input logic [6:0] cv, input logic [4:0] rv, input int len,
                               input int fv, input int er, input int ch, input int cc, input bit chkf);
    step_t s;
    s.cv = cv; s.rv = rv; s.len = len; s.fv = fv; s.er = er; s.ch = ch; s.cc = cc; s.chkf = chkf;
    steps.push_back(s);
  endfunction

  function automatic void col_step(input int c, input int len, input int fv, input int ch);
    push(7'(1) << c, pat(c), len, fv, 0, ch, c, fv != 0);
  endfunction

  function automatic void scan(input int ch);
    for (int c = 0; c < 7; c++) col_step(c, 10, c == 6 ? 1 : 0, c == 6 ? ch : 0);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, want);
    end
  endtask

  task automatic run(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      int nfh, nfl, neh, nel, nch, ncl;
      nfh = 0; nfl = 0; neh = 0; nel = 0; nch = 0; ncl = 0;
      col = steps[i].cv;
      row = steps[i].rv;
      repeat (steps[i].len) begin
        @(negedge clk);
        nfh += int'(fv_h); nfl += int'(fv_l);
        neh += int'(er_h); nel += int'(er_l);
        nch += int'(ch_h); ncl += int'(ch_l);
      end
      check($sformatf("step%0d frame_valid", i), 64'(nfh), 64'(steps[i].fv));
      check($sformatf("step%0d frame_valid_low", i), 64'(nfl), 64'(steps[i].fv));
      check($sformatf("step%0d col_err", i), 64'(neh), 64'(steps[i].er));
      check($sformatf("step%0d col_err_low", i), 64'(nel), 64'(steps[i].er));
      check($sformatf("step%0d frame_changed", i), 64'(nch), 64'(steps[i].ch));
      check($sformatf("step%0d frame_changed_low", i), 64'(ncl), 64'(steps[i].ch));
      check($sformatf("step%0d cur_col", i), 64'(cc_h), 64'(steps[i].cc));
      check($sformatf("step%0d cur_col_low", i), 64'(cc_l), 64'(steps[i].cc));
      if (steps[i].chkf) begin
        check($sformatf("step%0d frame", i), 64'(frame_h), 64'(want_frame));
        check($sformatf("step%0d frame_low", i), 64'(frame_l), 64'(want_frame));
      end
    end
  endtask

  initial begin
    int end_a, end_b;
    want_frame = '0;
    for (int c = 0; c < 7; c++) want_frame |= 35'(pat(c)) << (c * 5);
    // first scan, repeat, glitch during column 3, out-of-order, blanked scan, multi-select
    push(7'd0, 5'd0, 4, 0, 0, 0, 0, 1'b0);
    scan(1);
    scan(0);
    for (int c = 0; c < 3; c++) col_step(c, 10, 0, 0);
    col_step(3, 6, 0, 0);
    push(7'b0100000, 5'b00000, 2, 0, 0, 0, 3, 1'b0);
    col_step(3, 6, 0, 0);
    for (int c = 4; c < 7; c++) col_step(c, 10, c == 6 ? 1 : 0, 0);
    for (int c = 0; c < 3; c++) col_step(c, 10, 0, 0);
    push(7'b0010000, pat(4), 10, 0, 1, 0, 2, 1'b0);
    scan(0);
    for (int c = 0; c < 7; c++) begin
      col_step(c, 10, c == 6 ? 1 : 0, 0);
      push(7'd0, 5'd0, 3, 0, 0, 0, c, 1'b0);
    end
    col_step(0, 10, 0, 0);
    col_step(1, 10, 0, 0);
    push(7'b0001100, 5'd0, 6, 0, 1, 0, 1, 1'b0);
    end_a = steps.size();
    for (int c = 0; c < 5; c++) col_step(c, 10, 0, 0);
    end_b = steps.size();
    scan(1);
    push(7'd0, 5'd0, 20, 0, 0, 0, 6, 1'b1);

    rst = 1'b1;
    col = '0;
    row = '0;
    repeat (3) @(negedge clk);
    check("reset frame", 64'(frame_h), 64'(0));
    check("reset frame_low", 64'(frame_l), 64'(0));
    check("reset frame_valid", 64'(fv_h), 64'(0));
    check("reset frame_changed", 64'(ch_h), 64'(0));
    check("reset col_err", 64'(er_h), 64'(0));
    check("reset cur_col", 64'(cc_h), 64'(0));
    check("reset col_err_low", 64'(er_l), 64'(0));
    rst = 1'b0;

    run(0, end_a);
    check("multi state", 64'(dut.state), 64'(HUNT));
    check("multi state_low", 64'(dut_l.state), 64'(HUNT));
    run(end_a, end_b);
    rst = 1'b1;
    @(negedge clk);
    check("midreset frame", 64'(frame_h), 64'(0));
    check("midreset frame_low", 64'(frame_l), 64'(0));
    check("midreset frame_valid", 64'(fv_h), 64'(0));
    check("midreset frame_valid_low", 64'(fv_l), 64'(0));
    check("midreset cur_col", 64'(cc_h), 64'(0));
    rst = 1'b0;
    run(end_b, steps.size());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
